// File: rtl/arith_result_collector.sv
// Result collector: tags in-flight operands through a ce-gated pipe and captures tagged results into a FWFT FIFO.
// Optional macro RESULT_SAT_EN clamps captured results to the signed 32-bit range and raises a sticky sat flag.
module arith_result_collector #(
   parameter int unsigned DATA_W  = 40,
   parameter int unsigned LATENCY = 5,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ce,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          res,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       sat
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [LATENCY-1:0] r_tag;
   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic               r_out_valid;
   logic               r_overflow;

   logic               w_cap;
   logic               w_pop;
   logic               w_full;
   logic               w_wr;
   logic               w_drop;
   logic [CW-1:0]      w_count_nxt;
   logic [DATA_W-1:0]  w_wdata;

   // Valid tag advances in lock-step with the upstream datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag <= '0;
      end else if (ce) begin
         r_tag[0] <= in_valid;
         for (int i = 1; i < int'(LATENCY); i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign w_cap  = ce & r_tag[LATENCY-1];
   assign w_pop  = r_out_valid & out_ready;
   assign w_full = (r_count == CW'(DEPTH));
   assign w_wr   = w_cap & (~w_full | w_pop);
   assign w_drop = w_cap & w_full & ~w_pop;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // FIFO storage, pointers, occupancy and drop flag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wdata;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count     <= w_count_nxt;
         r_out_valid <= (w_count_nxt != '0);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef RESULT_SAT_EN
   logic r_sat;
   logic w_clamp;

   // Out of range when the bits above bit 30 are not a pure sign extension
   if (DATA_W > 32) begin : g_clamp
      localparam int unsigned HW = DATA_W - 31;
      logic [HW-1:0] w_hi;
      assign w_hi    = res[DATA_W-1:31];
      assign w_clamp = ~((&w_hi) | ~(|w_hi));
      assign w_wdata = ~w_clamp ? res :
                       (res[DATA_W-1] ? {{HW{1'b1}}, {31{1'b0}}}
                                      : {{HW{1'b0}}, {31{1'b1}}});
   end else begin : g_noclamp
      assign w_clamp = 1'b0;
      assign w_wdata = res;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat <= 1'b0;
      end else if (w_wr & w_clamp) begin
         r_sat <= 1'b1;
      end
   end

   assign sat = r_sat;
`else
   assign w_wdata = res;
   assign sat     = 1'b0;
`endif

   assign out_data  = r_mem[r_rd_ptr];
   assign out_valid = r_out_valid;
   assign count     = r_count;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_arith_result_collector.sv
// Bench for arith_result_collector: directed scenarios plus random traffic against a queue-based reference model.
module tb_arith_result_collector;

   localparam int unsigned DATA_W  = 40;
   localparam int unsigned LATENCY = 5;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned CW      = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst;
   logic              ce;
   logic              in_valid;
   logic [DATA_W-1:0] res;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              sat;

   int checks   = 0;
   int failures = 0;

   // Reference model: remaining ce-edges per in-flight launch, and FIFO contents
   int                rem_q[$];
   logic [DATA_W-1:0] fifo_q[$];
   bit                m_ovf;
   bit                m_sat;

   arith_result_collector #(.DATA_W(DATA_W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .res(res),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .overflow(overflow), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] ref_store(input logic [DATA_W-1:0] v, output bit clamped);
      longint s;
      s = longint'($signed(v));
      clamped = 1'b0;
`ifdef RESULT_SAT_EN
      if (s > 64'sd2147483647) begin
         s = 64'sd2147483647;
         clamped = 1'b1;
      end else if (s < -64'sd2147483648) begin
         s = -64'sd2147483648;
         clamped = 1'b1;
      end
`endif
      return DATA_W'(s);
   endfunction

   task automatic model_edge();
      bit do_pop;
      bit do_cap;
      bit clamped;
      int nq[$];
      logic [DATA_W-1:0] w;
      if (rst) begin
         rem_q.delete();
         fifo_q.delete();
         m_ovf = 1'b0;
         m_sat = 1'b0;
         return;
      end
      do_pop = (fifo_q.size() > 0) && out_ready;
      do_cap = 1'b0;
      if (ce) begin
         foreach (rem_q[i]) begin
            if (rem_q[i] == 1) do_cap = 1'b1;
            else nq.push_back(rem_q[i] - 1);
         end
         if (in_valid) nq.push_back(int'(LATENCY));
         rem_q = nq;
      end
      if (do_pop) void'(fifo_q.pop_front());
      if (do_cap) begin
         w = ref_store(res, clamped);
         if (fifo_q.size() < int'(DEPTH)) begin
            fifo_q.push_back(w);
            if (clamped) m_sat = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic compare();
      chk("out_valid", 64'(out_valid), 64'(fifo_q.size() > 0));
      chk("count", 64'(count), 64'(fifo_q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("sat", 64'(sat), 64'(m_sat));
      if (fifo_q.size() > 0) chk("out_data", 64'(out_data), 64'(fifo_q[0]));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic drive(input logic c, input logic iv, input logic rdy, input logic [DATA_W-1:0] r);
      ce = c; in_valid = iv; out_ready = rdy; res = r;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, '0);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0; res = '0;
      step();
      step();
      rst = 1'b0;
      chk("reset_out_data", 64'(out_data), 64'h0);
      chk("reset_out_valid", 64'(out_valid), 64'h0);

      // Single result: visible 6 edges after launch
      drive(1'b1, 1'b1, 1'b0, 40'h00_0000_1234);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 40'h00_0000_1234);
      chk("single_not_yet", 64'(out_valid), 64'h0);
      drive(1'b1, 1'b0, 1'b0, 40'h00_0000_1234);
      chk("single_valid", 64'(out_valid), 64'h1);
      chk("single_data", 64'(out_data), 64'h1234);
      chk("single_count", 64'(count), 64'h1);
      drive(1'b1, 1'b0, 1'b1, '0);
      chk("single_drained", 64'(count), 64'h0);
      chk("single_valid_low", 64'(out_valid), 64'h0);

      // Stall: 3 ce-low cycles delay the result by exactly 3
      drive(1'b1, 1'b1, 1'b0, DATA_W'($urandom));
      drive(1'b1, 1'b0, 1'b0, DATA_W'($urandom));
      drive(1'b1, 1'b0, 1'b0, DATA_W'($urandom));
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, DATA_W'($urandom));
      n = 6;
      while (!out_valid && n < 20) begin
         drive(1'b1, 1'b0, 1'b0, {8'h0, 32'($urandom)});
         n++;
      end
      chk("stall_latency", 64'(n), 64'd9);
      drive(1'b1, 1'b0, 1'b1, '0);

      // Overflow: 6 launches into a 4-deep FIFO
      for (int s = 1; s <= 11; s++)
         drive(1'b1, s <= 6, 1'b0, (s >= 6) ? DATA_W'(s - 5) : '0);
      chk("ovf_count", 64'(count), 64'd4);
      chk("ovf_flag", 64'(overflow), 64'h1);
      for (int k = 1; k <= 4; k++) begin
         chk("ovf_drain", 64'(out_data), 64'(k));
         drive(1'b1, 1'b0, 1'b1, '0);
      end
      do_reset();
      chk("ovf_cleared", 64'(overflow), 64'h0);

      // Full plus simultaneous pop
      for (int s = 1; s <= 10; s++)
         drive(1'b1, s <= 5, s == 10, (s >= 6) ? DATA_W'(s - 5) : '0);
      chk("fullpop_count", 64'(count), 64'd4);
      chk("fullpop_ovf", 64'(overflow), 64'h0);
      for (int k = 2; k <= 5; k++) begin
         chk("fullpop_drain", 64'(out_data), 64'(k));
         drive(1'b1, 1'b0, 1'b1, '0);
      end

      // Reset with 2 stored and 2 in flight
      for (int s = 1; s <= 7; s++) drive(1'b1, s <= 4, 1'b0, DATA_W'($urandom));
      chk("rstmid_pre", 64'(count), 64'd2);
      do_reset();
      chk("rstmid_count", 64'(count), 64'h0);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, DATA_W'($urandom));
      chk("rstmid_flushed", 64'(out_valid), 64'h0);

      // Clamp boundary values
      for (int s = 1; s <= 7; s++)
         drive(1'b1, s <= 2, 1'b0, (s == 6) ? 40'h01_0000_0000 : (s == 7) ? 40'hFF_0000_0000 : '0);
`ifdef RESULT_SAT_EN
      chk("sat_pos", 64'(out_data), 64'h00_7FFF_FFFF);
      drive(1'b1, 1'b0, 1'b1, '0);
      chk("sat_neg", 64'(out_data), 64'hFF_8000_0000);
      chk("sat_flag", 64'(sat), 64'h1);
`else
      chk("nosat_pos", 64'(out_data), 64'h01_0000_0000);
      drive(1'b1, 1'b0, 1'b1, '0);
      chk("nosat_neg", 64'(out_data), 64'hFF_0000_0000);
      chk("nosat_flag", 64'(sat), 64'h0);
`endif
      do_reset();

      // Random traffic with stalls, back-pressure and rare resets
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
               ($urandom_range(0, 1) == 1) ? {DATA_W'($urandom), 8'($urandom)} : DATA_W'($signed(32'($urandom))));
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
